// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: instruction funct
// codes, FSM state encoding and funct-group decode helpers.
package muldiv_pkg;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Any of the eight HI/LO-group instructions.
    function automatic logic is_hilo(input logic [5:0] f);
        return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
    endfunction

    // mult/multu/div/divu: bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider datapath.
// Multiply: right-shifting shift-add, {acc,mq} ends as the full product.
// Divide: restoring shift-subtract, acc ends as remainder, mq as quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] mq_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] mq_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Compute both step flavours and select by operation kind.
    always_comb begin
        sum    = {1'b0, acc_i} + (mq_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh = {acc_i, mq_i[WIDTH-1]};
        // Partial remainder stays below the divisor, so diff[WIDTH] is a clean borrow.
        diff   = rem_sh - {1'b0, opnd_i};
        if (div_i) begin
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = rem_sh[WIDTH-1:0];
                mq_o  = {mq_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            mq_o  = {sum[0], mq_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: accepts mult/div ops in IDLE, iterates WIDTH
// RUN cycles through muldiv_step, applies sign correction in FIX and writes
// HI/LO on the edge that leaves FIX. mthi/mtlo/mfhi/mflo complete in IDLE.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    import muldiv_pkg::*;

    localparam int CW = $clog2(WIDTH);

    state_e             state_q;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   acc_q, mq_q, opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               div_q, neg_a_q, neg_b_q, divz_q;

    logic [WIDTH-1:0]   acc_d, mq_d, hi_d, lo_d;
    logic               idle, accept_md, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod, prod_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (div_q),
        .acc_i  (acc_q),
        .mq_i   (mq_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_d),
        .mq_o   (mq_d)
    );

    // Decode the presented op and form operand magnitudes for signed ops.
    always_comb begin
        idle      = (state_q == S_IDLE);
        accept_md = op_valid & idle & is_muldiv(funct);
        signed_op = ~funct[0];
        a_neg     = signed_op & a[WIDTH-1];
        b_neg     = signed_op & b[WIDTH-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Sign-correct the raw iteration result into the HI/LO values written at the end of FIX.
    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        if (!div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else if (divz_q) begin
            // Zero divisor: quotient is all ones; acc holds |a|, restore a's sign to return a itself.
            lo_d = '1;
            hi_d = neg_a_q ? -acc_q : acc_q;
        end else begin
            lo_d = (neg_a_q ^ neg_b_q) ? -mq_q : mq_q;
            hi_d = neg_a_q ? -acc_q : acc_q;
        end
    end

    // Control FSM, iteration counter, working registers and architectural HI/LO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_md) begin
                        state_q <= S_RUN;
                        count_q <= '0;
                        acc_q   <= '0;
                        div_q   <= funct[1];
                        neg_a_q <= a_neg;
                        neg_b_q <= b_neg;
                        divz_q  <= funct[1] & (b == '0);
                        // Divide shifts the dividend out of mq; multiply consumes the multiplier from mq.
                        mq_q    <= funct[1] ? a_mag : b_mag;
                        opnd_q  <= funct[1] ? b_mag : a_mag;
                    end else if (op_valid && funct == F_MTHI) begin
                        hi_q <= a;
                    end else if (op_valid && funct == F_MTLO) begin
                        lo_q <= a;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    mq_q    <= mq_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    count_q <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Status, stall and move-from read port.
    always_comb begin
        busy   = ~idle;
        done   = (state_q == S_FIX);
        stall  = op_valid & busy & is_hilo(funct);
        result = '0;
        if (op_valid && idle) begin
            if (funct == F_MFHI)      result = hi_q;
            else if (funct == F_MFLO) result = lo_q;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed mult/div/move vectors with
// hand-computed HI/LO; a monitor checks HI/LO after every done pulse.
module tb_muldiv_unit;
    localparam int W = 32;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         stall, busy, done;
    logic [W-1:0] result, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic done_seen = 1'b0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the negedge after a done pulse sees the freshly written HI/LO.
    always @(negedge clk) begin
        if (done_seen) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
            end
        end
        done_seen = done;
    end

    task automatic run_md(input string name, input logic [5:0] f, input logic [W-1:0] aa,
                          input logic [W-1:0] bb, input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        int bcnt, dcnt;
        logic [W-1:0] hi_old, lo_old;
        e.name = name; e.hi = eh; e.lo = el;
        sb_q.push_back(e);
        hi_old = hi; lo_old = lo;
        op_valid = 1'b1; funct = f; a = aa; b = bb;
        @(posedge clk); #1;
        op_valid = 1'b0; funct = '0; a = '0; b = '0;
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            bcnt++;
            if (done) dcnt++;
            if (bcnt == W / 2) begin
                check({name, "_hi_held"}, hi, hi_old);
                check({name, "_lo_held"}, lo, lo_old);
            end
        end
        check({name, "_busy_cycles"}, W'(bcnt), W'(W + 1));
        check({name, "_done_cycles"}, W'(dcnt), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int scnt;
        exp_t e;
        reset = 1'b0; op_valid = 1'b0; funct = '0; a = '0; b = '0;
        #12;
        check("rst_busy",   W'(busy),  32'd0);
        check("rst_stall",  W'(stall), 32'd0);
        check("rst_done",   W'(done),  32'd0);
        check("rst_hi",     hi,        32'd0);
        check("rst_lo",     lo,        32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);

        run_md("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_md("mult_m3x5", MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        run_md("div_m7d2",  DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("divu_10d0", DIVU,  32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF);
        run_md("div_minm1", DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_md("div_7dm2",  DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        run_md("div_m5d0",  DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);

        // mthi then mfhi, no stall
        op_valid = 1'b1; funct = MTHI; a = 32'h12345678;
        #1 check("mthi_stall", W'(stall), 32'd0);
        @(posedge clk); #1;
        funct = MFHI; a = '0;
        @(negedge clk);
        check("mfhi_result", result, 32'h12345678);
        check("mfhi_stall",  W'(stall), 32'd0);
        @(posedge clk); #1;
        funct = MTLO; a = 32'hCAFEF00D;
        @(posedge clk); #1;
        funct = MFLO; a = '0;
        @(negedge clk);
        check("mflo_result", result, 32'hCAFEF00D);
        check("mthi_kept",   hi,     32'h12345678);
        op_valid = 1'b0;
        @(negedge clk);

        // mflo issued right behind a mult stalls until the cycle after done
        e.name = "mult_7x6"; e.hi = 32'd0; e.lo = 32'd42;
        sb_q.push_back(e);
        op_valid = 1'b1; funct = MULT; a = 32'd7; b = 32'd6;
        @(posedge clk); #1;
        funct = MFLO; a = '0; b = '0;
        scnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!stall) break;
            scnt++;
        end
        check("mflo_stall_cycles", W'(scnt), W'(W + 1));
        check("mflo_after_mult",   result,   32'd42);
        @(posedge clk); #1;
        op_valid = 1'b0; funct = '0;
        @(negedge clk);

        // Unrecognised funct is ignored
        op_valid = 1'b1; funct = 6'b100000; a = 32'hFFFFFFFF;
        #1;
        check("bad_funct_stall",  W'(stall), 32'd0);
        check("bad_funct_result", result,    32'd0);
        @(posedge clk); #1;
        check("bad_funct_busy",   W'(busy),  32'd0);
        check("bad_funct_hi",     hi,        32'd0);
        check("bad_funct_lo",     lo,        32'd42);
        op_valid = 1'b0; funct = '0; a = '0;
        @(negedge clk);

        run_md("multu_sh4", MULTU, 32'h12345678, 32'h10, 32'h00000001, 32'h23456780);

        // Reset in the middle of RUN
        op_valid = 1'b1; funct = MULTU; a = 32'hDEADBEEF; b = 32'h11111111;
        @(posedge clk); #1;
        funct = 6'b100001;
        @(negedge clk);
        check("busy_bad_funct_stall", W'(stall), 32'd0);
        op_valid = 1'b0; funct = '0; a = '0; b = '0;
        repeat (15) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", W'(busy), 32'd0);
        check("midrst_done", W'(done), 32'd0);
        check("midrst_hi",   hi,       32'd0);
        check("midrst_lo",   lo,       32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        run_md("multu_2x3", MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        repeat (3) @(negedge clk);
        check("sb_drained", W'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
